// File: rtl/frame_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_stream_ctrl: sequences one image run from the filter into the sink.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module frame_stream_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic                    i_start,
  input  logic [15:0]             i_width,
  input  logic [15:0]             i_high,
  input  logic [15:0]             i_frames,
  input  logic [DATA_WIDTH*3-1:0] i_in_data,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  output logic [DATA_WIDTH*3-1:0] o_out_data,
  output logic                    o_out_valid,
  output logic                    o_stop,
  output logic                    o_sof,
  output logic                    o_eol,
  output logic                    o_eof,
  output logic [15:0]             o_x_cnt,
  output logic [15:0]             o_y_cnt,
  output logic [15:0]             o_frame_cnt,
  output logic                    o_busy,
  output logic                    o_cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [15:0]             r_w;
  logic [15:0]             r_h;
  logic [15:0]             r_f;
  logic [15:0]             r_x;
  logic [15:0]             r_y;
  logic [15:0]             r_frame;
  logic [DATA_WIDTH*3-1:0] r_out_data;
  logic                    r_out_valid;
  logic                    r_stop;
  logic                    r_sof;
  logic                    r_eol;
  logic                    r_eof;
  logic                    r_cfg_err;

  logic w_launch;
  logic w_geom_ok;
  logic w_accept;
  logic w_x_last;
  logic w_y_last;
  logic w_f_last;
  logic w_first;

  assign w_launch  = (r_state == S_IDLE) & i_start & i_enable;
  assign w_geom_ok = (i_width != 16'd0) & (i_high != 16'd0) & (i_frames != 16'd0);
  assign w_accept  = (r_state == S_RUN) & i_enable & i_in_valid;
  assign w_x_last  = (r_x == r_w - 16'd1);
  assign w_y_last  = (r_y == r_h - 16'd1);
  assign w_f_last  = (r_frame == r_f - 16'd1);
  assign w_first   = (r_x == 16'd0) & (r_y == 16'd0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch && w_geom_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_x_last && w_y_last && w_f_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_w         <= 16'd0;
      r_h         <= 16'd0;
      r_f         <= 16'd0;
      r_x         <= 16'd0;
      r_y         <= 16'd0;
      r_frame     <= 16'd0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_stop      <= 1'b0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_eof       <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stop      <= (r_state == S_DONE);
      r_out_valid <= w_accept;
      r_sof       <= w_accept & w_first;
      r_eol       <= w_accept & w_x_last;
      r_eof       <= w_accept & w_x_last & w_y_last;
      if (w_accept) begin
        r_out_data <= i_in_data;
        // Final pixel lets frame count reach F, marking the run complete
        if (w_x_last) begin
          r_x <= 16'd0;
          if (w_y_last) begin
            r_y     <= 16'd0;
            r_frame <= r_frame + 16'd1;
          end else begin
            r_y <= r_y + 16'd1;
          end
        end else begin
          r_x <= r_x + 16'd1;
        end
      end
      if (w_launch) begin
        r_w       <= i_width;
        r_h       <= i_high;
        r_f       <= i_frames;
        r_x       <= 16'd0;
        r_y       <= 16'd0;
        r_frame   <= 16'd0;
        r_cfg_err <= ~w_geom_ok;
      end
    end
  end

  assign o_in_ready  = (r_state == S_RUN) & i_enable;
  assign o_busy      = (r_state != S_IDLE);
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_stop      = r_stop;
  assign o_sof       = r_sof;
  assign o_eol       = r_eol;
  assign o_eof       = r_eof;
  assign o_x_cnt     = r_x;
  assign o_y_cnt     = r_y;
  assign o_frame_cnt = r_frame;
  assign o_cfg_err   = r_cfg_err;

endmodule
`default_nettype wire
